// File: rtl/q294_ti_pipe_if.sv
// Beat-level handshake and 3-share data bus for the Q294 threshold pipe.
// The slave modport is the pipe's view; the master modport is the S-box sequencer's view.
interface q294_ti_pipe_if #(
    parameter int NIBBLES = 16
);
    logic                   in_valid;
    logic                   in_ready;
    logic [4*NIBBLES-1:0]   in_sh0;
    logic [4*NIBBLES-1:0]   in_sh1;
    logic [4*NIBBLES-1:0]   in_sh2;
    logic [NIBBLES-1:0]     nib_en;
    logic                   out_valid;
    logic                   out_ready;
    logic [4*NIBBLES-1:0]   out_sh0;
    logic [4*NIBBLES-1:0]   out_sh1;
    logic [4*NIBBLES-1:0]   out_sh2;

    modport slave (
        input  in_valid, in_sh0, in_sh1, in_sh2, nib_en, out_ready,
        output in_ready, out_valid, out_sh0, out_sh1, out_sh2
    );

    modport master (
        output in_valid, in_sh0, in_sh1, in_sh2, nib_en, out_ready,
        input  in_ready, out_valid, out_sh0, out_sh1, out_sh2
    );
endinterface

// File: rtl/q294_ti_pipe.sv
// 3-share threshold implementation of quadratic class Q294, valid/ready pipelined.
// Output share i depends only on input shares i and i+1 (mod 3); shares are never recombined.
module q294_ti_pipe #(
    parameter int NIBBLES = 16,   // 1..16
    parameter int STAGES  = 1     // 1 or 2
) (
    input  logic          clk,
    input  logic          rst_n,
    q294_ti_pipe_if.slave bus
);
    localparam int W = 4 * NIBBLES;

    function automatic logic [3:0] share_fn(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] y;
        y[3] = a[3];
        y[2] = a[2];
        y[1] = a[1] ^ (a[3] & a[2]) ^ (a[3] & b[2]) ^ (b[3] & a[2]);
        y[0] = a[0] ^ (a[3] & a[1]) ^ (a[3] & b[1]) ^ (b[3] & a[1]);
        return y;
    endfunction

    logic               w_f_valid;
    logic               w_f_ready;
    logic [W-1:0]       w_f_sh0;
    logic [W-1:0]       w_f_sh1;
    logic [W-1:0]       w_f_sh2;
    logic [NIBBLES-1:0] w_f_en;
    logic [W-1:0]       w_y_sh0;
    logic [W-1:0]       w_y_sh1;
    logic [W-1:0]       w_y_sh2;

    logic               r_out_valid;
    logic [W-1:0]       r_out_sh0;
    logic [W-1:0]       r_out_sh1;
    logic [W-1:0]       r_out_sh2;

    genvar gi;

    generate
        if (STAGES == 2) begin : g_in_reg
            logic               r_s1_valid;
            logic [W-1:0]       r_s1_sh0;
            logic [W-1:0]       r_s1_sh1;
            logic [W-1:0]       r_s1_sh2;
            logic [NIBBLES-1:0] r_s1_en;
            logic               w_in_ready;

            assign w_in_ready   = !r_s1_valid || w_f_ready;
            assign bus.in_ready = w_in_ready;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_s1_valid <= 1'b0;
                    r_s1_sh0   <= '0;
                    r_s1_sh1   <= '0;
                    r_s1_sh2   <= '0;
                    r_s1_en    <= '0;
                end else begin
                    if (w_in_ready) begin
                        r_s1_valid <= bus.in_valid;
                    end
                    // Data moves only on an actual transfer so idle cycles cause no share toggling.
                    if (bus.in_valid && w_in_ready) begin
                        r_s1_sh0 <= bus.in_sh0;
                        r_s1_sh1 <= bus.in_sh1;
                        r_s1_sh2 <= bus.in_sh2;
                        r_s1_en  <= bus.nib_en;
                    end
                end
            end

            assign w_f_valid = r_s1_valid;
            assign w_f_sh0   = r_s1_sh0;
            assign w_f_sh1   = r_s1_sh1;
            assign w_f_sh2   = r_s1_sh2;
            assign w_f_en    = r_s1_en;
        end else begin : g_no_in_reg
            assign bus.in_ready = w_f_ready;
            assign w_f_valid    = bus.in_valid;
            assign w_f_sh0      = bus.in_sh0;
            assign w_f_sh1      = bus.in_sh1;
            assign w_f_sh2      = bus.in_sh2;
            assign w_f_en       = bus.nib_en;
        end
    endgenerate

    generate
        for (gi = 0; gi < NIBBLES; gi++) begin : g_nib
            assign w_y_sh0[4*gi +: 4] = w_f_en[gi] ? share_fn(w_f_sh0[4*gi +: 4], w_f_sh1[4*gi +: 4])
                                                   : w_f_sh0[4*gi +: 4];
            assign w_y_sh1[4*gi +: 4] = w_f_en[gi] ? share_fn(w_f_sh1[4*gi +: 4], w_f_sh2[4*gi +: 4])
                                                   : w_f_sh1[4*gi +: 4];
            assign w_y_sh2[4*gi +: 4] = w_f_en[gi] ? share_fn(w_f_sh2[4*gi +: 4], w_f_sh0[4*gi +: 4])
                                                   : w_f_sh2[4*gi +: 4];
        end
    endgenerate

    // The output register is the glitch barrier after the nonlinear layer.
    assign w_f_ready = !r_out_valid || bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_sh0   <= '0;
            r_out_sh1   <= '0;
            r_out_sh2   <= '0;
        end else begin
            if (w_f_ready) begin
                r_out_valid <= w_f_valid;
            end
            if (w_f_valid && w_f_ready) begin
                r_out_sh0 <= w_y_sh0;
                r_out_sh1 <= w_y_sh1;
                r_out_sh2 <= w_y_sh2;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_sh0   = r_out_sh0;
    assign bus.out_sh1   = r_out_sh1;
    assign bus.out_sh2   = r_out_sh2;
endmodule

// File: tb/tb_q294_ti_pipe.sv
// Randomized bench for q294_ti_pipe: a 1-nibble/1-stage instance and a 16-nibble/2-stage instance,
// both checked against an unshared reference of the Q294 map via recombination of the output shares.
module tb_q294_ti_pipe;
    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    typedef struct {
        logic [63:0] s0;
        logic [63:0] s1;
        logic [63:0] s2;
        logic [15:0] en;
        int          cyc;
        logic        lat_chk;
    } beat_t;

    beat_t qb[$];
    int    nb_in  = 0;
    int    nb_out = 0;
    logic  lat_flag = 1'b0;
    logic  stalled_prev = 1'b0;

    q294_ti_pipe_if #(.NIBBLES(1))  ifa ();
    q294_ti_pipe_if #(.NIBBLES(16)) ifb ();

    q294_ti_pipe #(.NIBBLES(1), .STAGES(1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    q294_ti_pipe #(.NIBBLES(16), .STAGES(2)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Unshared Q294: y = {x3, x2, x1^x3x2, x0^x3x1}
    function automatic logic [3:0] q294(input logic [3:0] x);
        return {x[3], x[2], x[1] ^ (x[3] & x[2]), x[0] ^ (x[3] & x[1])};
    endfunction

    function automatic logic [63:0] model_y(input logic [63:0] x, input logic [15:0] en);
        logic [63:0] y;
        y = '0;
        for (int n = 0; n < 16; n++) begin
            y[4*n +: 4] = en[n] ? q294(x[4*n +: 4]) : x[4*n +: 4];
        end
        return y;
    endfunction

    task automatic check_beat(input beat_t b, input logic [63:0] o0, input logic [63:0] o1,
                              input logic [63:0] o2);
        logic [63:0] mask;
        mask = '0;
        for (int n = 0; n < 16; n++) begin
            if (!b.en[n]) mask[4*n +: 4] = 4'hF;
        end
        chk("b_recomb", o0 ^ o1 ^ o2, model_y(b.s0 ^ b.s1 ^ b.s2, b.en));
        chk("b_pass_sh0", o0 & mask, b.s0 & mask);
        chk("b_pass_sh1", o1 & mask, b.s1 & mask);
        chk("b_pass_sh2", o2 & mask, b.s2 & mask);
    endtask

    // Scoreboard for the 16-nibble instance, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (stalled_prev) chk("b_stall_valid", 64'(ifb.out_valid), 64'd1);
                if (ifb.out_valid) begin
                    if (qb.size() == 0) begin
                        chk("b_extra_beat", 64'(ifb.out_valid), 64'd0);
                    end else begin
                        check_beat(qb[0], ifb.out_sh0, ifb.out_sh1, ifb.out_sh2);
                        if (ifb.out_ready) begin
                            if (qb[0].lat_chk) chk("b_latency", 64'(cyc - qb[0].cyc), 64'd2);
                            void'(qb.pop_front());
                            nb_out++;
                        end
                    end
                end
                stalled_prev = ifb.out_valid && !ifb.out_ready;
                if (ifb.in_valid && ifb.in_ready) begin
                    qb.push_back('{ifb.in_sh0, ifb.in_sh1, ifb.in_sh2, ifb.nib_en, cyc, lat_flag});
                    nb_in++;
                end
            end else begin
                stalled_prev = 1'b0;
            end
        end
    end

    task automatic a_beat(input logic [3:0] s0, input logic [3:0] s1, input logic [3:0] s2,
                          input logic en);
        logic [3:0] x;
        logic [3:0] exp;
        x   = s0 ^ s1 ^ s2;
        exp = en ? q294(x) : x;
        @(posedge clk); #1;
        ifa.in_valid = 1'b1;
        ifa.in_sh0   = s0;
        ifa.in_sh1   = s1;
        ifa.in_sh2   = s2;
        ifa.nib_en   = en;
        @(negedge clk);
        chk("a_out_valid_pre", 64'(ifa.out_valid), 64'd0);
        chk("a_in_ready", 64'(ifa.in_ready), 64'd1);
        @(posedge clk); #1;
        ifa.in_valid = 1'b0;
        @(negedge clk);
        chk("a_out_valid", 64'(ifa.out_valid), 64'd1);
        chk("a_recomb", 64'(ifa.out_sh0 ^ ifa.out_sh1 ^ ifa.out_sh2), 64'(exp));
        if (!en) begin
            chk("a_pass_sh0", 64'(ifa.out_sh0), 64'(s0));
            chk("a_pass_sh1", 64'(ifa.out_sh1), 64'(s1));
            chk("a_pass_sh2", 64'(ifa.out_sh2), 64'(s2));
        end
    endtask

    task automatic b_drive(input logic v, input logic rdy, input logic lat);
        @(posedge clk); #1;
        ifb.in_valid  = v;
        ifb.out_ready = rdy;
        ifb.in_sh0    = {$urandom, $urandom};
        ifb.in_sh1    = {$urandom, $urandom};
        ifb.in_sh2    = {$urandom, $urandom};
        ifb.nib_en    = ($urandom_range(0, 3) == 0) ? 16'h00FF : 16'($urandom);
        lat_flag      = lat;
    endtask

    task automatic b_drain(input string tag);
        repeat (5) b_drive(1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk(tag, 64'(qb.size()), 64'd0);
        chk("b_beat_count", 64'(nb_out), 64'(nb_in));
    endtask

    initial begin
        logic [3:0] r0;
        logic [3:0] r1;
        rst_n         = 1'b0;
        ifa.in_valid  = 1'b0;
        ifa.in_sh0    = '0;
        ifa.in_sh1    = '0;
        ifa.in_sh2    = '0;
        ifa.nib_en    = '0;
        ifa.out_ready = 1'b1;
        ifb.in_valid  = 1'b0;
        ifb.in_sh0    = '0;
        ifb.in_sh1    = '0;
        ifb.in_sh2    = '0;
        ifb.nib_en    = '0;
        ifb.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_out_valid", 64'(ifa.out_valid), 64'd0);
        chk("rst_a_out_sh", 64'({ifa.out_sh0, ifa.out_sh1, ifa.out_sh2}), 64'd0);
        chk("rst_a_in_ready", 64'(ifa.in_ready), 64'd1);
        chk("rst_b_out_valid", 64'(ifb.out_valid), 64'd0);
        chk("rst_b_out_sh0", ifb.out_sh0, 64'd0);
        chk("rst_b_out_sh1", ifb.out_sh1, 64'd0);
        chk("rst_b_out_sh2", ifb.out_sh2, 64'd0);
        chk("rst_b_in_ready", 64'(ifb.in_ready), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single-nibble instance: directed F -> C, then every value under a random split.
        a_beat(4'hF, 4'h0, 4'h0, 1'b1);
        for (int v = 0; v < 16; v++) begin
            r0 = 4'($urandom);
            r1 = 4'($urandom);
            a_beat(r0, r1, 4'(v) ^ r0 ^ r1, 1'b1);
        end
        a_beat(4'($urandom), 4'($urandom), 4'($urandom), 1'b0);

        // Free-running stream: one beat per cycle, fixed 2-cycle latency.
        repeat (40) begin
            b_drive(1'b1, 1'b1, 1'b1);
            @(negedge clk);
            chk("b_in_ready_run", 64'(ifb.in_ready), 64'd1);
        end
        b_drain("b_drain_run");

        // Five-cycle output stall while the source keeps offering beats.
        repeat (3) b_drive(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            b_drive(1'b1, 1'b0, 1'b0);
            @(negedge clk);
            if (i >= 1) chk("b_stall_in_ready", 64'(ifb.in_ready), 64'd0);
        end
        b_drain("b_drain_stall");

        // Random valid/ready traffic.
        repeat (200) b_drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0), 1'b0);
        b_drain("b_drain_rand");

        // Reset mid-stream.
        repeat (3) b_drive(1'b1, 1'b1, 1'b0);
        @(posedge clk); #1;
        rst_n        = 1'b0;
        ifb.in_valid = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(ifb.out_valid), 64'd0);
        chk("mid_rst_out_sh0", ifb.out_sh0, 64'd0);
        chk("mid_rst_out_sh1", ifb.out_sh1, 64'd0);
        chk("mid_rst_out_sh2", ifb.out_sh2, 64'd0);
        chk("mid_rst_in_ready", 64'(ifb.in_ready), 64'd1);
        qb.delete();
        nb_in  = 0;
        nb_out = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        b_drive(1'b1, 1'b1, 1'b1);
        b_drain("b_drain_post_rst");
        chk("b_post_rst_beats", 64'(nb_out), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
